// File: rtl/decode_fwd_scoreboard.sv
// decode_fwd_scoreboard: decode-stage operand bypass with a multi-cycle producer scoreboard
module decode_fwd_scoreboard #(
  parameter int XLEN = 32,
  parameter int NUM_SRC = 2,
  parameter int STALL_CW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr_d,
  input  logic                    valid_d,
  input  logic [NUM_SRC*XLEN-1:0] rf_data_d,
  input  logic                    we_exmem,
  input  logic [4:0]              rd_exmem,
  input  logic [XLEN-1:0]         data_exmem,
  input  logic                    we_memwb,
  input  logic [4:0]              rd_memwb,
  input  logic [XLEN-1:0]         data_memwb,
  input  logic                    ml_issue,
  input  logic [4:0]              ml_rd,
  input  logic                    ml_done,
  input  logic [4:0]              ml_done_rd,
  input  logic [XLEN-1:0]         ml_done_data,
  output logic [NUM_SRC*XLEN-1:0] fwd_data_d,
  output logic                    stall_d,
  output logic [31:0]             pending,
  output logic [STALL_CW-1:0]     stall_cycles,
  output logic                    stall_sat
);
  logic [NUM_SRC-1:0] haz;
  logic [31:0] set_m, clr_m;
  logic unused_ok;
  assign unused_ok = ^{instr_d[14:0], instr_d[26:25], instr_d[31:27]};
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [4:0] rs;
    assign rs = g == 0 ? instr_d[19:15] : g == 1 ? instr_d[24:20] : instr_d[31:27];
    assign fwd_data_d[g*XLEN +: XLEN] = rs == 5'd0 ? '0 :
                                        (we_exmem && rd_exmem == rs) ? data_exmem :
                                        (we_memwb && rd_memwb == rs) ? data_memwb :
                                        (ml_done && ml_done_rd == rs) ? ml_done_data :
                                        rf_data_d[g*XLEN +: XLEN];
    // a returning result releases its consumer in the same cycle
    assign haz[g] = rs != 5'd0 && pending[rs] && !(ml_done && ml_done_rd == rs);
  end
  assign stall_d = valid_d && |haz;
  // a producer held in decode by a stall has not issued yet, so it must not mark its rd
  assign set_m = (ml_issue && !stall_d && ml_rd != 5'd0) ? 32'd1 << ml_rd : '0;
  assign clr_m = ml_done ? 32'd1 << ml_done_rd : '0;
  assign stall_sat = &stall_cycles;
  // scoreboard: clear returning result, then set new producer so the newer one wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else pending <= (pending & ~clr_m) | set_m;
  end
  // saturating count of consecutive stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else stall_cycles <= !stall_d ? '0 : stall_sat ? stall_cycles : stall_cycles + STALL_CW'(1);
  end
endmodule
